alu_cmd_sequencer: RTL and testbench

//  Upstream command stage for the unsigned ALU. Buffers {A,B,OP} commands in a FIFO and

---
 rtl/alu_cmd_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
//   Command front end for the unsigned 8-bit ALU. {A,B,OP} commands are queued
//   in a small FIFO and issued one at a time on the ALU pins. Each result is
//   captured on alu_done and returned on a valid/ready response port. Illegal
//   opcodes (110/111) and an ALU that never answers within TIMEOUT WAIT cycles
//   produce an error response with zero data.
//
// Ports
//   CLK, rst_n            clock (rising edge), synchronous active-low reset
//   cmd_valid/cmd_ready   command handshake; cmd_ready = FIFO not full
//   cmd_a, cmd_b, cmd_op  command operands and opcode
//   alu_en                one-cycle enable pulse per issued command
//   alu_a, alu_b, alu_op  operands presented to the ALU (held between issues)
//   alu_result, alu_done  ALU answer; done is only honoured while waiting
//   rsp_valid/rsp_ready   response handshake
//   rsp_data, rsp_err     16-bit result, or 0 with rsp_err=1 on error
//   fifo_level            current FIFO occupancy
module alu_cmd_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 8
) (
  input  logic                   CLK,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [7:0]             cmd_a,
  input  logic [7:0]             cmd_b,
  input  logic [2:0]             cmd_op,
  output logic                   alu_en,
  output logic [7:0]             alu_a,
  output logic [7:0]             alu_b,
  output logic [2:0]             alu_op,
  input  logic [15:0]            alu_result,
  input  logic                   alu_done,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [15:0]            rsp_data,
  output logic                   rsp_err,
  output logic [$clog2(DEPTH):0] fifo_level
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  // FIFO entry layout: {op, b, a}
  logic [18:0]    mem_q [DEPTH];
  logic [18:0]    mem_d [DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]  level_q, level_d;
  state_t         state_q, state_d;
  logic           ill_q, ill_d;
  logic [CW-1:0]  tcnt_q, tcnt_d;
  logic [7:0]     alu_a_q, alu_a_d;
  logic [7:0]     alu_b_q, alu_b_d;
  logic [2:0]     alu_op_q, alu_op_d;
  logic [15:0]    rsp_data_q, rsp_data_d;
  logic           rsp_err_q, rsp_err_d;

  logic           push, pop;
  logic [18:0]    head;
  logic           head_legal;

  assign cmd_ready  = (level_q != LW'(DEPTH));
  assign fifo_level = level_q;
  assign head       = mem_q[rd_ptr_q];
  assign head_legal = (head[18:16] <= 3'd5);

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  // An illegal command still spends its ISSUE slot, but never enables the ALU.
  assign alu_en     = (state_q == S_ISSUE) && !ill_q;
  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_data   = rsp_data_q;
  assign rsp_err    = rsp_err_q;

  // FIFO bookkeeping
  always_comb begin
    push     = cmd_valid && cmd_ready;
    pop      = (state_q == S_IDLE) && (level_q != '0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      mem_d[wr_ptr_q] = {cmd_op, cmd_b, cmd_a};
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (!push && pop) begin
      level_d = level_q - LW'(1);
    end
  end

  // Sequencer FSM: next state and registered datapath updates
  always_comb begin
    state_d    = state_q;
    ill_d      = ill_q;
    tcnt_d     = tcnt_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    unique case (state_q)
      S_IDLE: begin
        if (pop) begin
          state_d = S_ISSUE;
          ill_d   = !head_legal;
          // Only legal commands ever reach the ALU pins.
          if (head_legal) begin
            alu_a_d  = head[7:0];
            alu_b_d  = head[15:8];
            alu_op_d = head[18:16];
          end
        end
      end
      S_ISSUE: begin
        tcnt_d = '0;
        if (ill_q) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = S_RESP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (alu_done) begin
          rsp_data_d = alu_result;
          rsp_err_d  = 1'b0;
          state_d    = S_RESP;
        end else if (tcnt_q == CW'(TIMEOUT - 1)) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = S_RESP;
        end else begin
          tcnt_d = tcnt_q + CW'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ill_q      <= 1'b0;
      tcnt_q     <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ill_q      <= ill_d;
      tcnt_q     <= tcnt_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // FIFO storage carries no reset; emptiness is tracked by the pointers.
  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
module tb_alu_cmd_sequencer;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;

  logic                   CLK = 1'b0;
  logic                   rst_n;
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [7:0]             cmd_a;
  logic [7:0]             cmd_b;
  logic [2:0]             cmd_op;
  logic                   alu_en;
  logic [7:0]             alu_a;
  logic [7:0]             alu_b;
  logic [2:0]             alu_op;
  logic [15:0]            alu_result;
  logic                   alu_done;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [15:0]            rsp_data;
  logic                   rsp_err;
  logic [$clog2(DEPTH):0] fifo_level;

  alu_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_en(alu_en), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_done(alu_done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .fifo_level(fifo_level)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   en_cnt = 0;

  // environment knobs
  bit hang     = 1'b0;   // ALU never answers
  bit rand_dly = 1'b0;   // random ALU latency 0..5 extra cycles
  bit spur_en  = 1'b0;   // stray alu_done pulses while the ALU is idle
  bit stim_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Behavioural ALU arithmetic (unsigned, 16-bit result)
  function automatic logic [15:0] alu_func(input logic [7:0] a, input logic [7:0] b,
                                           input logic [2:0] op);
    case (op)
      3'd0:    return 16'(a) + 16'(b);
      3'd1:    return 16'(a) * 16'(b);
      3'd2:    return {8'h00, a & b};
      3'd3:    return {8'h00, a | b};
      3'd4:    return {8'h00, a ^ b};
      3'd5:    return {8'h00, ~a};
      default: return 16'h0000;
    endcase
  endfunction

  function automatic exp_t expect_of(input logic [7:0] a, input logic [7:0] b,
                                     input logic [2:0] op, input bit no_answer);
    exp_t e;
    if (op > 3'd5 || no_answer) begin
      e.data = 16'h0000;
      e.err  = 1'b1;
    end else begin
      e.data = alu_func(a, b, op);
      e.err  = 1'b0;
    end
    return e;
  endfunction

  // ALU model: sees alu_en mid-cycle, raises a one-cycle done after its latency.
  bit          alu_busy = 1'b0;
  int          alu_dly  = 0;
  logic [15:0] alu_pend = '0;
  always @(negedge CLK) begin
    alu_done = 1'b0;
    if (!rst_n) begin
      alu_busy = 1'b0;
    end else begin
      if (alu_busy) begin
        if (alu_dly == 0) begin
          alu_done   = 1'b1;
          alu_result = alu_pend;
          alu_busy   = 1'b0;
        end else begin
          alu_dly--;
        end
      end else if (!hang && spur_en && $urandom_range(0, 7) == 0) begin
        alu_done   = 1'b1;
        alu_result = 16'($urandom);
      end
      if (alu_en && !hang) begin
        alu_busy = 1'b1;
        alu_dly  = rand_dly ? int'($urandom_range(0, 5)) : 0;
        alu_pend = alu_func(alu_a, alu_b, alu_op);
      end
    end
  end

  // Response monitor / scoreboard
  exp_t        mon_e;
  bit          held = 1'b0;
  logic [15:0] hold_data;
  logic        hold_err;
  always @(negedge CLK) begin
    #1;
    if (alu_en) en_cnt++;
    if (rsp_valid) begin
      if (held) begin
        chk("rsp_hold_data", 32'(rsp_data), 32'(hold_data));
        chk("rsp_hold_err", 32'(rsp_err), 32'(hold_err));
      end
      if (rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL rsp_unexpected: got data 0x%0h err %0b, required no response at %0t",
                   rsp_data, rsp_err, $time);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rsp_data", 32'(rsp_data), 32'(mon_e.data));
          chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
        end
        held = 1'b0;
      end else begin
        held      = 1'b1;
        hold_data = rsp_data;
        hold_err  = rsp_err;
      end
    end else begin
      held = 1'b0;
    end
  end

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    int n = 0;
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 300) begin
      @(negedge CLK);
      n++;
    end
    chk("cmd_accept", 32'(cmd_ready), 32'd1);
    if (cmd_ready) exp_q.push_back(expect_of(a, b, op, hang));
    @(negedge CLK);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || rsp_valid) && n < 1000) begin
      @(negedge CLK);
      n++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge CLK);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1);
  end

  initial begin
    int e0;
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_a      = '0;
    cmd_b      = '0;
    cmd_op     = '0;
    rsp_ready  = 1'b1;
    alu_result = '0;
    alu_done   = 1'b0;
    repeat (3) @(negedge CLK);

    // reset state
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_alu_en", 32'(alu_en), 32'd0);
    chk("rst_alu_abop", 32'({alu_a, alu_b, alu_op}), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'({rsp_err, rsp_data}), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    rst_n = 1'b1;
    @(negedge CLK);

    // ADD 200+100 with exact latency
    e0 = en_cnt;
    send(8'd200, 8'd100, 3'd0);
    chk("add_level_k", 32'(fifo_level), 32'd1);
    chk("add_en_k", 32'(alu_en), 32'd0);
    @(negedge CLK);
    chk("add_en_k1", 32'(alu_en), 32'd1);
    chk("add_alu_pins", 32'({alu_op, alu_a, alu_b}), 32'({3'd0, 8'd200, 8'd100}));
    @(negedge CLK);
    chk("add_en_k2", 32'(alu_en), 32'd0);
    chk("add_vld_k2", 32'(rsp_valid), 32'd0);
    @(negedge CLK);
    chk("add_vld_k3", 32'(rsp_valid), 32'd1);
    chk("add_data_k3", 32'({rsp_err, rsp_data}), 32'({1'b0, 16'd300}));
    drain();
    chk("add_en_pulses", 32'(en_cnt - e0), 32'd1);

    // MUL 255*255 then NOTA 0x0F, in order
    e0 = en_cnt;
    send(8'd255, 8'd255, 3'd1);
    send(8'h0F, 8'h33, 3'd5);
    drain();
    chk("mul_nota_pulses", 32'(en_cnt - e0), 32'd2);

    // illegal opcode then XOR
    e0 = en_cnt;
    send(8'h12, 8'h34, 3'b110);
    chk("ill_vld_k", 32'(rsp_valid), 32'd0);
    @(negedge CLK);
    chk("ill_en_k1", 32'(alu_en), 32'd0);
    chk("ill_vld_k1", 32'(rsp_valid), 32'd0);
    @(negedge CLK);
    chk("ill_vld_k2", 32'(rsp_valid), 32'd1);
    chk("ill_data_k2", 32'({rsp_err, rsp_data}), 32'({1'b1, 16'd0}));
    drain();
    send(8'hAA, 8'h55, 3'd4);
    drain();
    chk("ill_xor_pulses", 32'(en_cnt - e0), 32'd1);

    // backpressure: DEPTH+2 commands with rsp_ready low
    rsp_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++)
      send(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));
    @(negedge CLK);
    chk("bp_level_full", 32'(fifo_level), 32'(DEPTH));
    chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    fork
      send(8'($urandom), 8'($urandom), 3'($urandom_range(0, 5)));
      begin
        repeat (6) begin
          @(negedge CLK);
          chk("bp_blocked", 32'({cmd_ready, rsp_valid}), 32'b01);
        end
        rsp_ready = 1'b1;
      end
    join
    drain();

    // ALU never answers: timeout response, then recovery
    hang = 1'b1;
    send(8'd7, 8'd9, 3'd0);
    repeat (TIMEOUT + 1) @(negedge CLK);
    chk("to_vld_early", 32'(rsp_valid), 32'd0);
    @(negedge CLK);
    chk("to_vld", 32'(rsp_valid), 32'd1);
    chk("to_data", 32'({rsp_err, rsp_data}), 32'({1'b1, 16'd0}));
    drain();
    hang = 1'b0;
    send(8'd13, 8'd11, 3'd1);
    drain();

    // reset during WAIT with two commands queued
    hang = 1'b1;
    send(8'd1, 8'd2, 3'd0);
    send(8'd3, 8'd4, 3'd1);
    send(8'd5, 8'd6, 3'd2);
    chk("rst_mid_level", 32'(fifo_level), 32'd2);
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge CLK);
    chk("rst_mid_en", 32'(alu_en), 32'd0);
    chk("rst_mid_vld", 32'(rsp_valid), 32'd0);
    chk("rst_mid_level0", 32'(fifo_level), 32'd0);
    chk("rst_mid_ready", 32'(cmd_ready), 32'd1);
    rst_n = 1'b1;
    hang  = 1'b0;
    e0    = 0;
    repeat (20) begin
      @(negedge CLK);
      if (rsp_valid || alu_en) e0++;
    end
    chk("rst_mid_stale", 32'(e0), 32'd0);

    // randomized traffic with random latency, stray done pulses and backpressure
    rand_dly  = 1'b1;
    spur_en   = 1'b1;
    stim_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          send(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));
          repeat ($urandom_range(0, 3)) @(negedge CLK);
        end
        stim_done = 1'b1;
      end
      begin
        while (!stim_done) begin
          @(negedge CLK);
          rsp_ready = ($urandom_range(0, 3) != 0);
        end
        rsp_ready = 1'b1;
      end
    join
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
